topk_sort_engine: RTL

TOPK_SORT_ENGINE -- requirements
Module: topk_sort_engine

---
 rtl/topk_sort_engine_if.sv | 29 ++
 rtl/topk_sort_engine.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/topk_sort_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : topk_sort_engine_if
// Purpose  : Insertion and drain handshake bundle for topk_sort_engine.
//            master = record producer / drain consumer, slave = sort engine.
// Revision : 1.0 - initial release
// ============================================================================
interface topk_sort_engine_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface
`default_nettype wire

// File: rtl/topk_sort_engine.sv
`default_nettype none
// ============================================================================
// Module   : topk_sort_engine
// Purpose  : Keeps the best K records in a systolic sorted array (entry 0 is
//            best). Records are inserted one per cycle; a drain request
//            streams all held entries out in rank order.
//            Optional macro SORT_DROP_CNT_EN adds a saturating drop counter.
// Revision : 1.0 - initial release
// ============================================================================
module topk_sort_engine #(
   parameter int K          = 128,
   parameter int DATA_WIDTH = 64,
   parameter int KEY_LSB    = 0,
   parameter int KEY_WIDTH  = 32
) (
   input  wire logic                  clk,
   input  wire logic                  reset_n,
   input  wire logic                  i_clear,
   input  wire logic                  i_order,
   input  wire logic                  i_drain_req,
   topk_sort_engine_if.slave          bus,
   output logic [$clog2(K+1)-1:0]     o_count,
   output logic                       o_full,
   output logic [KEY_WIDTH-1:0]       o_threshold
`ifdef SORT_DROP_CNT_EN
   ,
   output logic [31:0]                o_drop_cnt
`endif
);

   localparam int                 CNT_W    = $clog2(K+1);
   localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(K);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

   typedef enum logic [0:0] {
      ST_FILL  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_mode;            // 0 = descending, 1 = ascending
   logic [CNT_W-1:0]      r_count;
   logic [CNT_W-1:0]      w_count_nxt;
   logic [K-1:0]          r_valid;
   logic [K-1:0]          w_valid_nxt;
   logic [DATA_WIDTH-1:0] r_data      [K];
   logic [DATA_WIDTH-1:0] w_data_nxt  [K];
   logic [K-1:0]          w_better;          // cell ranks better-or-equal to new key
   logic [KEY_WIDTH-1:0]  w_new_key;
   logic                  w_in_fire;
   logic                  w_out_fire;
   logic                  w_full;
   logic                  w_discard;
   logic                  w_insert;

   assign w_new_key  = bus.in_data[KEY_LSB +: KEY_WIDTH];
   assign w_full     = (r_count == CNT_FULL);
   assign w_in_fire  = bus.in_valid && (r_state == ST_FILL);
   assign w_out_fire = (r_state == ST_DRAIN) && r_valid[0] && bus.out_ready;
   // Valid cells form a prefix, so when full, "K-1 is better-or-equal" means
   // every cell is and the record has nowhere to go.
   assign w_discard  = w_in_fire && w_full && w_better[K-1];
   assign w_insert   = w_in_fire && !w_discard;

   assign bus.in_ready  = (r_state == ST_FILL);
   assign bus.out_valid = (r_state == ST_DRAIN) && r_valid[0];
   assign bus.out_data  = r_data[0];
   assign bus.out_last  = (r_state == ST_DRAIN) && (r_count == CNT_ONE);
   assign o_count       = r_count;
   assign o_full        = w_full;
   assign o_threshold   = w_full ? r_data[K-1][KEY_LSB +: KEY_WIDTH]
                                 : (r_mode ? {KEY_WIDTH{1'b1}} : {KEY_WIDTH{1'b0}});

   // Per-cell comparison of the stored key against the incoming key (ties count as better)
   always_comb begin
      w_better = '0;
      for (int i = 0; i < K; i++) begin
         if (r_mode)
            w_better[i] = r_valid[i] && (r_data[i][KEY_LSB +: KEY_WIDTH] <= w_new_key);
         else
            w_better[i] = r_valid[i] && (r_data[i][KEY_LSB +: KEY_WIDTH] >= w_new_key);
      end
   end

   // Next array contents: shift up on a drain beat, or open a slot and shift down on insert
   always_comb begin
      w_valid_nxt = r_valid;
      for (int i = 0; i < K; i++) w_data_nxt[i] = r_data[i];
      if (w_out_fire) begin
         for (int i = 0; i < K-1; i++) begin
            w_valid_nxt[i] = r_valid[i+1];
            w_data_nxt[i]  = r_data[i+1];
         end
         w_valid_nxt[K-1] = 1'b0;
      end else if (w_insert) begin
         if (!w_better[0]) begin
            w_valid_nxt[0] = 1'b1;
            w_data_nxt[0]  = bus.in_data;
         end
         for (int i = 1; i < K; i++) begin
            if (!w_better[i]) begin
               if (w_better[i-1]) begin
                  w_valid_nxt[i] = 1'b1;
                  w_data_nxt[i]  = bus.in_data;
               end else begin
                  w_valid_nxt[i] = r_valid[i-1];
                  w_data_nxt[i]  = r_data[i-1];
               end
            end
         end
      end
      if (i_clear) w_valid_nxt = '0;
   end

   // Occupancy count: grows until full, shrinks per drain beat, flushed by clear
   always_comb begin
      w_count_nxt = r_count;
      if (i_clear)
         w_count_nxt = '0;
      else if (w_insert && !w_full)
         w_count_nxt = r_count + CNT_ONE;
      else if (w_out_fire)
         w_count_nxt = r_count - CNT_ONE;
   end

   // FILL/DRAIN sequencing; an empty drain bounces straight back to FILL
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_FILL:  if (i_drain_req) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if ((r_count == '0) || (w_out_fire && (r_count == CNT_ONE)))
                      w_state_nxt = ST_FILL;
         default:  w_state_nxt = ST_FILL;
      endcase
      if (i_clear) w_state_nxt = ST_FILL;
   end

   // Control registers; sort mode only follows the order input while empty and filling
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_FILL;
         r_count <= '0;
         r_valid <= '0;
         r_mode  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_valid <= w_valid_nxt;
         if ((r_state == ST_FILL) && (r_count == '0))
            r_mode <= i_order;
      end
   end

   // Record payload storage; qualified by r_valid so it needs no reset
   always_ff @(posedge clk) begin
      r_data <= w_data_nxt;
   end

`ifdef SORT_DROP_CNT_EN
   logic [31:0] r_drop_cnt;
   assign o_drop_cnt = r_drop_cnt;

   // Saturating count of records rejected by a full array
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_drop_cnt <= '0;
      else if (i_clear)
         r_drop_cnt <= '0;
      else if (w_discard && (r_drop_cnt != 32'hFFFF_FFFF))
         r_drop_cnt <= r_drop_cnt + 32'd1;
   end
`endif

endmodule
`default_nettype wire
